// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and constants for the ram_sdp block
package ram_pkg;

    // Clear-sweep controller states
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Legal read latencies
    localparam int RD_LAT_1 = 1;
    localparam int RD_LAT_2 = 2;

endpackage

// File: rtl/ram_init_ctrl.sv
// rtl/ram_init_ctrl.sv - clear-sweep FSM and address counter for ram_sdp
module ram_init_ctrl
    import ram_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_req,
    output logic              init_busy,
    output logic [ADDR_W-1:0] init_ptr,
    output logic              init_we
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;

    // State and sweep pointer; reset always lands in INIT at address 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next state: sweep one word per cycle, requests during a sweep are ignored
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            INIT: begin
                if (r_ptr == LAST_ADDR) begin
                    w_state_nxt = RUN;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
            RUN: begin
                if (init_req) begin
                    w_state_nxt = INIT;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = INIT;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    assign init_busy = (r_state == INIT);
    assign init_we   = (r_state == INIT);
    assign init_ptr  = r_ptr;

endmodule

// File: rtl/ram_sdp.sv
// rtl/ram_sdp.sv - simple dual-port RAM with clear sweep; RAM_BYPASS_EN selects write-first collisions
module ram_sdp
    import ram_pkg::*;
#(
    parameter int                DATA_W   = 36,
    parameter int                DEPTH    = 32,
    parameter int                ADDR_W   = $clog2(DEPTH),
    parameter int                RD_LAT   = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              init_req,
    output logic              init_busy
);

    // One extra bit so DEPTH itself is representable when it is a power of two
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_init_busy;
    logic              w_init_we;
    logic [ADDR_W-1:0] w_init_ptr;
    logic              w_run;
    logic              w_wr_ok;
    logic              w_rd_req;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_rd_in_range;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    ram_init_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_init_ctrl (
        .clk       (clk),
        .rst       (rst),
        .init_req  (init_req),
        .init_busy (w_init_busy),
        .init_ptr  (w_init_ptr),
        .init_we   (w_init_we)
    );

    assign w_run   = !w_init_busy;
    assign w_wr_ok = w_run && wr_en && ({1'b0, wr_addr} < DEPTH_W);

    // Array write port: sweep has priority, user writes only in RUN and in range
    always_ff @(posedge clk) begin
        if (w_init_we) begin
            r_mem[w_init_ptr] <= INIT_VAL;
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    if (RD_LAT == RD_LAT_2) begin : g_lat2
        logic              r_req_q;
        logic [ADDR_W-1:0] r_addr_q;

        // Address stage: requests accepted in RUN stay in flight across a new sweep
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_req_q  <= 1'b0;
                r_addr_q <= '0;
            end else begin
                r_req_q <= w_run && rd_en;
                if (rd_en) begin
                    r_addr_q <= rd_addr;
                end
            end
        end

        assign w_rd_req  = r_req_q;
        assign w_rd_addr = r_addr_q;
    end else begin : g_lat1
        assign w_rd_req  = w_run && rd_en;
        assign w_rd_addr = rd_addr;
    end

    assign w_rd_in_range = ({1'b0, w_rd_addr} < DEPTH_W);

`ifdef RAM_BYPASS_EN
    logic w_fwd;
    assign w_fwd     = w_wr_ok && (wr_addr == w_rd_addr);
    assign w_rd_word = !w_rd_in_range ? '0 : (w_fwd ? wr_data : r_mem[w_rd_addr]);
`else
    assign w_rd_word = w_rd_in_range ? r_mem[w_rd_addr] : '0;
`endif

    // Output stage: data holds between reads, valid pulses once per accepted read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd_req;
            if (w_rd_req) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign init_busy = w_init_busy;

endmodule
